sram_ctrl: RTL and testbench
============================

# sram_ctrl

Synchronous front-end for the team's 8K×8 asynchronous SRAM (6264-style: `cs1_n`, `cs2`, `we_n`, `oe_n`, 13-bit address, shared 8-bit bidirectional data bus).
- Accepts single-byte read/write requests over a valid/ready handshake.
- Sequences the chip strobes with programmable setup, pulse and hold cycle counts, and returns one response per request.
- Sits directly upstream of the SRAM: every pin of the memory is driven from this block.

## Interface
Parameters:
- `ADDR_W`, 13: address width.
- `DATA_W`, 8: data width.
- `SETUP_CYC`, 1: cycles of address/data setup before the strobe. Must be ≥1.
- `PULSE_CYC`, 2: cycles `we_n`/`oe_n` are held low. Must be ≥1.
- `HOLD_CYC`, 1: cycles of address/data hold after `we_n` rises. Must be ≥1.

Ports:
- `clk`, in, 1: the only clock; all logic on its rising edge.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: block can accept a request.
- `req_we`, in, 1: 1 = write, 0 = read.
- `req_addr`, in, ADDR_W: byte address.
- `req_wdata`, in, DATA_W: write data.
- `rsp_valid`, out, 1: one-cycle response pulse.
- `rsp_rdata`, out, DATA_W: read data. 0 for writes, or readback when verify is compiled in.
- `rsp_err`, out, 1: verify mismatch. Exists only with `SRAM_CTRL_VERIFY_EN`.
- `sram_cs1_n`, out, 1: active-low chip select.
- `sram_cs2`, out, 1: active-high chip select.
- `sram_we_n`, out, 1: write strobe.
- `sram_oe_n`, out, 1: output enable.
- `sram_a`, out, ADDR_W: address.
- `sram_io`, inout, DATA_W: data bus.

## Operation
- FSM states: IDLE, RD_SETUP, RD_PULSE, WR_SETUP, WR_PULSE, WR_HOLD, RESP. VF_SETUP and VF_PULSE are added under the macro.
- `req_ready` = (state == IDLE). A request is accepted on a cycle where `req_valid && req_ready`.
- On accept, `req_we`, `req_addr` and `req_wdata` are captured into internal registers. Request inputs are ignored outside IDLE.
- Read sequence:
  - RD_SETUP (`SETUP_CYC` cycles): chip selected, `sram_a` valid, `oe_n` low, `we_n` high, `sram_io` high-Z.
  - RD_PULSE (`PULSE_CYC` cycles): same pin state. `sram_io` is sampled into `rsp_rdata` on the last RD_PULSE edge.
  - Then RESP.
- Write sequence:
  - WR_SETUP (`SETUP_CYC` cycles): chip selected, `sram_a` and `sram_io` driven, `we_n` high, `oe_n` high.
  - WR_PULSE (`PULSE_CYC` cycles): `we_n` low.
  - WR_HOLD (`HOLD_CYC` cycles): `we_n` high, address and data still driven.
  - Then RESP.
- RESP (1 cycle):
  - `rsp_valid` = 1, chip deselected (`cs1_n`=1, `cs2`=0), `sram_io` high-Z, `oe_n` high.
  - Next state is IDLE.
  - Back-to-back requests therefore always get at least two deselected cycles (RESP plus IDLE accept), which guarantees bus turnaround.
- Invariants:
  - `sram_io` is driven only in WR_* states.
  - `oe_n` is never low while `sram_io` is driven.
  - `we_n` and `oe_n` are never low together.
- Phase length is set by one down-counter, loaded with (count − 1) on phase entry. The phase advances when the counter reaches 0. Counter width is `$clog2` of the largest parameter plus 1.

## Timing
- All SRAM pins come straight from flops, so strobes are glitch-free.
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `sram_cs1_n`=1, `sram_cs2`=0, `sram_we_n`=1, `sram_oe_n`=1, `sram_a`=0, `sram_io` high-Z. State is IDLE.
- Latency with default parameters, accept edge = cycle 0:
  - Read: setup in cycle 1, pulse in cycles 2–3, `rsp_valid` in cycle 4.
  - Write: setup in 1, pulse in 2–3, hold in 4, `rsp_valid` in 5.
  - `req_ready` rises in the cycle after `rsp_valid`.
- General latency: read = SETUP+PULSE+1 cycles, write = SETUP+PULSE+HOLD+1 cycles.
- Reset asserted mid-operation: all strobes deassert and the bus goes high-Z immediately (asynchronously). A write in progress may be lost. No response is issued for it.
- Address wrap-around is not applicable; the full `ADDR_W` range is legal.

## Configuration
- `SRAM_CTRL_VERIFY_EN` defined: after WR_HOLD the FSM runs VF_SETUP/VF_PULSE, which is a read of the same address with read timing.
  - The readback goes to `rsp_rdata`.
  - `rsp_err` = (readback != written data), valid with `rsp_valid`.
  - Write latency grows by SETUP+PULSE (default: `rsp_valid` in cycle 8).
- Not defined: no VF states and no `rsp_err` port. Write responses carry `rsp_rdata`=0.

## Structure
- Package `sram_ctrl_pkg` holds:
  - the state enum typedef;
  - default timing constants (`SETUP_CYC`, `PULSE_CYC`, `HOLD_CYC` defaults);
  - the inactive strobe levels.
- One sub-module, `sram_ctrl_timer`: a loadable down-counter with a `done` output, shared by every phase.

## Test plan
- Reset, then write 0xA5 to 0x0000 and read 0x0000: `we_n` low for exactly 2 cycles; read returns 0xA5 with `rsp_valid` in cycle 4.
- Write 0x3C to 0x1FFF, write 0xC3 to 0x0001, read both: 0x3C and 0xC3. No cycle has `oe_n` low while `sram_io` is driven.
- `req_valid` held high with 8 alternating read/write requests: exactly one `rsp_valid` per accept, and at least 2 deselected cycles between transactions.
- Parameters SETUP=3, PULSE=4, HOLD=2: the bench measures strobe widths 3/4/2 cycles exactly; read latency is 8 cycles.
- `rst_n` pulsed low during WR_PULSE: `we_n`=1, `cs1_n`=1, `sram_io`=Z in the same cycle; after release `req_ready`=1 and no `rsp_valid`.
- With `SRAM_CTRL_VERIFY_EN` and the SRAM model's bit 0 stuck at 0, write 0x01: `rsp_rdata`=0x00, `rsp_err`=1. Write 0x02: `rsp_err`=0.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared state encoding, timing defaults and idle pin levels for sram_ctrl.
package sram_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_SETUP,
        RD_PULSE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RESP
`ifdef SRAM_CTRL_VERIFY_EN
        , VF_SETUP
        , VF_PULSE
`endif
    } state_t;

    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_PULSE_CYC = 2;
    localparam int DEF_HOLD_CYC  = 1;

    localparam logic CS1_N_OFF = 1'b1;
    localparam logic CS2_OFF   = 1'b0;
    localparam logic WE_N_OFF  = 1'b1;
    localparam logic OE_N_OFF  = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sram_ctrl_timer.sv
// sram_ctrl_timer: loadable phase down-counter; done_o is high while the count sits at zero.
module sram_ctrl_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= load_val_i;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: valid/ready front-end sequencing a 6264-style async SRAM from registered strobes.
// Define SRAM_CTRL_VERIFY_EN to read back every write and flag mismatches on rsp_err.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
`ifdef SRAM_CTRL_VERIFY_EN
    output logic              rsp_err,
`endif
    output logic              sram_cs1_n,
    output logic              sram_cs2,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic [ADDR_W-1:0] sram_a,
    inout  wire  [DATA_W-1:0] sram_io
);

    localparam int CW = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC)) + 1;
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rsp_valid_q;
    logic              cs1_n_q;
    logic              cs2_q;
    logic              we_n_q;
    logic              oe_n_q;
    logic              drive_q;
    logic              load;
    logic              done;
    logic [CW-1:0]     load_val;
`ifdef SRAM_CTRL_VERIFY_EN
    logic              err_q;
`endif

    sram_ctrl_timer #(.W(CW)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .load_val_i(load_val),
        .done_o    (done)
    );

    // Load the counter with the length of the phase being entered
    always_comb begin
        load     = 1'b0;
        load_val = SETUP_LD;
        case (state_q)
            IDLE:     load = req_valid;
            RD_SETUP: begin load = done; load_val = PULSE_LD; end
            WR_SETUP: begin load = done; load_val = PULSE_LD; end
            WR_PULSE: begin load = done; load_val = HOLD_LD; end
`ifdef SRAM_CTRL_VERIFY_EN
            WR_HOLD:  load = done;
            VF_SETUP: begin load = done; load_val = PULSE_LD; end
`endif
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            cs1_n_q     <= CS1_N_OFF;
            cs2_q       <= CS2_OFF;
            we_n_q      <= WE_N_OFF;
            oe_n_q      <= OE_N_OFF;
            drive_q     <= 1'b0;
`ifdef SRAM_CTRL_VERIFY_EN
            err_q       <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (req_valid) begin
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    cs1_n_q <= ~CS1_N_OFF;
                    cs2_q   <= ~CS2_OFF;
                    state_q <= req_we ? WR_SETUP : RD_SETUP;
                    drive_q <= req_we;
                    oe_n_q  <= req_we ? OE_N_OFF : ~OE_N_OFF;
                end
                RD_SETUP: if (done) state_q <= RD_PULSE;
                RD_PULSE: if (done) begin
                    rdata_q     <= sram_io;
                    rsp_valid_q <= 1'b1;
                    cs1_n_q     <= CS1_N_OFF;
                    cs2_q       <= CS2_OFF;
                    oe_n_q      <= OE_N_OFF;
                    state_q     <= RESP;
`ifdef SRAM_CTRL_VERIFY_EN
                    err_q       <= 1'b0;
`endif
                end
                WR_SETUP: if (done) begin
                    we_n_q  <= ~WE_N_OFF;
                    state_q <= WR_PULSE;
                end
                WR_PULSE: if (done) begin
                    we_n_q  <= WE_N_OFF;
                    state_q <= WR_HOLD;
                end
`ifdef SRAM_CTRL_VERIFY_EN
                // Release the bus and turn it round into a read of the same address
                WR_HOLD: if (done) begin
                    drive_q <= 1'b0;
                    oe_n_q  <= ~OE_N_OFF;
                    state_q <= VF_SETUP;
                end
                VF_SETUP: if (done) state_q <= VF_PULSE;
                VF_PULSE: if (done) begin
                    rdata_q     <= sram_io;
                    err_q       <= (sram_io != wdata_q);
                    rsp_valid_q <= 1'b1;
                    cs1_n_q     <= CS1_N_OFF;
                    cs2_q       <= CS2_OFF;
                    oe_n_q      <= OE_N_OFF;
                    state_q     <= RESP;
                end
`else
                WR_HOLD: if (done) begin
                    rdata_q     <= '0;
                    drive_q     <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    cs1_n_q     <= CS1_N_OFF;
                    cs2_q       <= CS2_OFF;
                    state_q     <= RESP;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rdata_q;
`ifdef SRAM_CTRL_VERIFY_EN
    assign rsp_err    = err_q;
`endif
    assign sram_cs1_n = cs1_n_q;
    assign sram_cs2   = cs2_q;
    assign sram_we_n  = we_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_a     = addr_q;
    assign sram_io    = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: scoreboard bench for sram_ctrl with a behavioural 6264 model and a slow-timing instance.
module tb_sram_ctrl;

`ifdef SRAM_CTRL_VERIFY_EN
    localparam bit VF = 1'b1;
`else
    localparam bit VF = 1'b0;
`endif
    localparam int WR_LAT  = VF ? 8 : 5;
    localparam int WR2_LAT = VF ? 17 : 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [12:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [7:0]  rsp_rdata;
    logic        sram_cs1_n, sram_cs2, sram_we_n, sram_oe_n;
    logic [12:0] sram_a;
    wire  [7:0]  sram_io;

    logic        v2 = 1'b0, we2 = 1'b0;
    logic [12:0] a2 = '0;
    logic [7:0]  d2 = '0;
    logic        ready2, rsp_valid2, rsp_err2;
    logic [7:0]  rsp_rdata2;
    logic        cs1_n2, cs2_2, we_n2, oe_n2;
    logic [12:0] sa2;
    wire  [7:0]  sram_io2;

    sram_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
`ifdef SRAM_CTRL_VERIFY_EN
        .rsp_err(rsp_err),
`endif
        .sram_cs1_n(sram_cs1_n), .sram_cs2(sram_cs2), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .sram_a(sram_a), .sram_io(sram_io)
    );

    sram_ctrl #(.SETUP_CYC(3), .PULSE_CYC(4), .HOLD_CYC(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(ready2), .req_we(we2),
        .req_addr(a2), .req_wdata(d2), .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
`ifdef SRAM_CTRL_VERIFY_EN
        .rsp_err(rsp_err2),
`endif
        .sram_cs1_n(cs1_n2), .sram_cs2(cs2_2), .sram_we_n(we_n2), .sram_oe_n(oe_n2),
        .sram_a(sa2), .sram_io(sram_io2)
    );

`ifndef SRAM_CTRL_VERIFY_EN
    assign rsp_err  = 1'b0;
    assign rsp_err2 = 1'b0;
`endif

    // A floating bus reads as 0xFF, so a released bus is observable
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (sram_io[g]);
        pullup (sram_io2[g]);
    end

    logic [7:0] mem [8192];
    logic [7:0] ref_mem [8192];
    logic       stuck = 1'b0;
    logic [7:0] rd_val;
    assign rd_val  = mem[sram_a] & ~{7'd0, stuck};
    assign sram_io = (!sram_cs1_n && sram_cs2 && !sram_oe_n) ? rd_val : 8'bz;
    always @(posedge sram_we_n) if (!sram_cs1_n && sram_cs2) mem[sram_a] = sram_io;
    assign sram_io2 = (!cs1_n2 && cs2_2 && !oe_n2) ? 8'h5A : 8'bz;

    logic [8:0] sbq [$];
    logic [8:0] exp_q;
    int passed = 0, total = 0, viol = 0, acc_cnt = 0, rsp_cnt = 0, desel = 0, min_gap = 99;
    bit seen_act = 1'b0;

    always @(negedge clk) begin
        if (rst_n && req_valid && req_ready) acc_cnt++;
        if (rsp_valid) begin
            rsp_cnt++;
            total++;
            if (sbq.size() == 0) begin
                $display("FAIL rsp_unexpected: rsp_valid with nothing outstanding, rdata=%h", rsp_rdata);
            end else begin
                exp_q = sbq.pop_front();
                if (rsp_rdata !== exp_q[7:0] || (VF && rsp_err !== exp_q[8]))
                    $display("FAIL scoreboard: rdata=%h err=%b, expected rdata=%h err=%b", rsp_rdata, rsp_err, exp_q[7:0], exp_q[8]);
                else
                    passed++;
            end
        end
        if ((!sram_we_n && !sram_oe_n) || (!sram_oe_n && sram_io !== rd_val) || (sram_cs1_n && sram_io !== 8'hFF))
            viol++;
        if (sram_cs1_n) desel++;
        else begin
            if (seen_act && desel > 0 && desel < min_gap) min_gap = desel;
            desel = 0;
            seen_act = 1'b1;
        end
    end

    task automatic send(input logic we, input logic [12:0] a, input logic [7:0] d, input logic [8:0] e, input bit keep);
        int n = 0;
        @(posedge clk); #1;
        req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
        if (we) ref_mem[a] = d;
        @(negedge clk);
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        if (!req_ready) begin
            total++;
            $display("FAIL accept_timeout: req_ready=%b, expected 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        sbq.push_back(e);
        @(posedge clk); #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin @(negedge clk); n++; end
        if (sbq.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    function automatic logic [8:0] wexp(input logic [7:0] d);
        return {1'b0, VF ? d : 8'h00};
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({req_ready, rsp_valid, rsp_rdata, sram_cs1_n, sram_cs2, sram_we_n, sram_oe_n, sram_a, rsp_err} !== {1'b1, 1'b0, 8'h00, 4'b1011, 13'h0, 1'b0})
            $display("FAIL reset_values: rdy=%b vld=%b rd=%h cs1n=%b cs2=%b wen=%b oen=%b a=%h err=%b, expected 1 0 00 1 0 1 1 0000 0",
                     req_ready, rsp_valid, rsp_rdata, sram_cs1_n, sram_cs2, sram_we_n, sram_oe_n, sram_a, rsp_err);
        else passed++;
        total++;
        if (sram_io !== 8'hFF) $display("FAIL reset_bus: sram_io=%h, expected released (FF)", sram_io);
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int wlow = 0, rc = 0, olow = 0;
        send(1'b1, 13'h0000, 8'hA5, wexp(8'hA5), 1'b0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (!sram_we_n) wlow++;
            if (rsp_valid && rc == 0) rc = c;
        end
        total++;
        if (wlow !== 2) $display("FAIL we_width: we_n low %0d cycles, expected 2", wlow); else passed++;
        total++;
        if (rc !== WR_LAT) $display("FAIL write_latency: rsp_valid in cycle %0d, expected %0d", rc, WR_LAT); else passed++;
        rc = 0;
        send(1'b0, 13'h0000, 8'h00, {1'b0, ref_mem[0]}, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (!sram_oe_n) olow++;
            if (rsp_valid && rc == 0) rc = c;
        end
        total++;
        if (rc !== 4) $display("FAIL read_latency: rsp_valid in cycle %0d, expected 4", rc); else passed++;
        total++;
        if (olow !== 3) $display("FAIL oe_width: oe_n low %0d cycles, expected 3", olow); else passed++;
    endtask

    task automatic test_patterns();
        int v0 = viol;
        send(1'b1, 13'h1FFF, 8'h3C, wexp(8'h3C), 1'b0); drain();
        send(1'b1, 13'h0001, 8'hC3, wexp(8'hC3), 1'b0); drain();
        send(1'b0, 13'h1FFF, 8'h00, {1'b0, 8'h3C}, 1'b0); drain();
        send(1'b0, 13'h0001, 8'h00, {1'b0, 8'hC3}, 1'b0); drain();
        total++;
        if (viol !== v0) $display("FAIL bus_invariant: %0d violating cycles, expected 0", viol - v0); else passed++;
    endtask

    task automatic test_back_to_back();
        int a0 = acc_cnt, r0 = rsp_cnt;
        min_gap = 99; seen_act = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) send(1'b1, 13'h0100 + 13'(i / 2), 8'h10 + 8'(i), wexp(8'h10 + 8'(i)), 1'b1);
            else            send(1'b0, 13'h0100 + 13'(i / 2), 8'h00, {1'b0, 8'h10 + 8'(i - 1)}, i < 7);
        end
        req_valid = 1'b0;
        drain();
        @(negedge clk);
        total++;
        if (acc_cnt - a0 !== 8 || rsp_cnt - r0 !== 8)
            $display("FAIL b2b_count: accepts=%0d responses=%0d, expected 8 and 8", acc_cnt - a0, rsp_cnt - r0);
        else passed++;
        total++;
        if (min_gap < 2) $display("FAIL b2b_gap: min deselected gap %0d cycles, expected >=2", min_gap); else passed++;
    endtask

    task automatic test_params();
        int su = 0, pw = 0, ho = 0, rc = 0, ol = 0;
        bit wl = 1'b0;
        logic [7:0] rdv = '0;
        for (int pass = 0; pass < 2; pass++) begin
            @(posedge clk); #1;
            we2 = (pass == 0); a2 = 13'h0042; d2 = 8'h3C; v2 = 1'b1;
            @(negedge clk);
            total++;
            if (!ready2) begin $display("FAIL p_ready: ready=%b, expected 1", ready2); v2 = 1'b0; return; end
            passed++;
            @(posedge clk); #1;
            v2 = 1'b0;
            rc = 0;
            for (int c = 1; c <= 25; c++) begin
                @(negedge clk);
                if (!we_n2) begin pw++; wl = 1'b1; end
                else if (!cs1_n2 && cs2_2 && oe_n2) begin if (wl) ho++; else su++; end
                if (!oe_n2) ol++;
                if (rsp_valid2 && rc == 0) begin rc = c; rdv = rsp_rdata2; end
            end
            if (pass == 0) begin
                total++;
                if (su !== 3 || pw !== 4 || ho !== 2) $display("FAIL p_strobes: setup/pulse/hold %0d/%0d/%0d, expected 3/4/2", su, pw, ho);
                else passed++;
                total++;
                if (rc !== WR2_LAT) $display("FAIL p_write_latency: cycle %0d, expected %0d", rc, WR2_LAT); else passed++;
                ol = 0;
            end else begin
                total++;
                if (rc !== 8) $display("FAIL p_read_latency: cycle %0d, expected 8", rc); else passed++;
                total++;
                if (ol !== 7 || rdv !== 8'h5A) $display("FAIL p_read: oe_n low %0d cycles data %h, expected 7 cycles data 5a", ol, rdv);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int r0;
        send(1'b1, 13'h00AA, 8'h77, wexp(8'h77), 1'b0);
        repeat (2) @(negedge clk);
        total++;
        if (sram_we_n !== 1'b0) $display("FAIL mid_pulse: we_n=%b, expected 0 in pulse", sram_we_n); else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if ({sram_we_n, sram_cs1_n, sram_oe_n} !== 3'b111 || sram_io !== 8'hFF)
            $display("FAIL async_reset: we_n=%b cs1_n=%b oe_n=%b io=%h, expected 1 1 1 FF", sram_we_n, sram_cs1_n, sram_oe_n, sram_io);
        else passed++;
        sbq.delete();
        r0 = rsp_cnt;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) $display("FAIL post_reset_ready: req_ready=%b, expected 1", req_ready); else passed++;
        repeat (10) @(negedge clk);
        total++;
        if (rsp_cnt !== r0) $display("FAIL post_reset_rsp: %0d responses, expected 0", rsp_cnt - r0); else passed++;
    endtask

`ifdef SRAM_CTRL_VERIFY_EN
    task automatic test_verify();
        stuck = 1'b1;
        send(1'b1, 13'h0055, 8'h01, {1'b1, 8'h00}, 1'b0); drain();
        send(1'b1, 13'h0056, 8'h02, {1'b0, 8'h02}, 1'b0); drain();
        stuck = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 8192; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
        test_reset();
        test_basic();
        test_patterns();
        test_back_to_back();
        test_params();
        test_reset_mid();
`ifdef SRAM_CTRL_VERIFY_EN
        test_verify();
`endif
        drain();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

endmodule
